mini16_uart_tx: RTL and testbench

MINI16_UART_TX -- requirements
Module: mini16_uart_tx

---
 rtl/mini16_uart_pkg.sv | 28 ++
 rtl/mini16_fifo.sv | 55 +++++
 rtl/mini16_uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_mini16_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini16_uart_pkg.sv
// mini16_uart_pkg -- shared definitions for the mini16 UART transmitter.
//   REG_*        : MMIO register addresses (data/status, divisor, overflow clear, reserved)
//   uart_state_e : transmitter FSM state encoding
// Optional feature macro: MINI16_UART_TX_PARITY_EN adds the PARITY state.
package mini16_uart_pkg;

  localparam int REG_DATA = 0;
  localparam int REG_DIV  = 1;
  localparam int REG_CLR  = 2;
  localparam int REG_RSVD = 3;

  // Status word bit positions (read of REG_DATA)
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MINI16_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/mini16_fifo.sv
// mini16_fifo -- synchronous FIFO with 2^DEPTH entries and a combinational read port.
//   clk, reset : clock and asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full or when popping
//   pop, dout  : read request; dout always shows the head entry
//   full/empty : occupancy flags, derived from pointers with one extra wrap bit
module mini16_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int ENTRIES = 1 << DEPTH;

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [DEPTH:0]   r_wptr;
  logic [DEPTH:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wptr == r_rptr);
  // Same slot index but different wrap bit means the writer is a full lap ahead.
  assign full  = (r_wptr[DEPTH] != r_rptr[DEPTH]) &&
                 (r_wptr[DEPTH-1:0] == r_rptr[DEPTH-1:0]);

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  assign dout = r_mem[r_rptr[DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[DEPTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/mini16_uart_tx.sv
// mini16_uart_tx -- MMIO-programmed UART transmitter with a TX FIFO.
//   clk, reset      : clock and asynchronous active-high reset
//   w_addr/w_data/we: MMIO write port (0 push byte, 1 divisor, 2 clear overflow)
//   r_addr/r_data   : MMIO read port, registered (0 status, 1 divisor, else 0)
//   txd             : serial output, idle high, 8N1 frames (8E1 with parity)
// Optional feature macro: MINI16_UART_TX_PARITY_EN (even parity bit after data).
module mini16_uart_tx
  import mini16_uart_pkg::*;
#(
  parameter int                 WIDTH_D     = 16,
  parameter int                 DEPTH_A     = 2,
  parameter int                 FIFO_DEPTH  = 4,
  parameter logic [WIDTH_D-1:0] DEFAULT_DIV = 16'd867
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH_A-1:0] w_addr,
  input  logic [WIDTH_D-1:0] w_data,
  input  logic               we,
  input  logic [DEPTH_A-1:0] r_addr,
  output logic [WIDTH_D-1:0] r_data,
  output logic               txd
);

  localparam logic [WIDTH_D-1:0] ONE_D = 1;

  logic               w_push_req;
  logic               w_div_we;
  logic               w_clr_we;
  logic               w_ovf_set;
  logic               w_fifo_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [7:0]         w_fifo_dout;
  logic [WIDTH_D-1:0] w_rdata;

  uart_state_e        r_state;
  uart_state_e        w_state_next;
  logic [WIDTH_D-1:0] r_div;
  logic [WIDTH_D-1:0] r_div_lat;
  logic [WIDTH_D-1:0] w_div_lat_next;
  logic [WIDTH_D-1:0] r_cnt;
  logic [WIDTH_D-1:0] w_cnt_next;
  logic [WIDTH_D-1:0] w_cnt_dec;
  logic [7:0]         r_byte;
  logic [7:0]         w_byte_next;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_next;
  logic [2:0]         w_bit_inc;
  logic               r_txd;
  logic               w_txd_next;
  logic               r_ovf;
  logic               w_bit_done;

  assign w_push_req = we && (w_addr == DEPTH_A'(REG_DATA));
  assign w_div_we   = we && (w_addr == DEPTH_A'(REG_DIV));
  assign w_clr_we   = we && (w_addr == DEPTH_A'(REG_CLR));
  assign w_ovf_set  = w_push_req && w_fifo_full && !w_fifo_pop;

  mini16_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .din   (w_data[7:0]),
    .pop   (w_fifo_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // A bit lasts divisor+1 clocks: the counter is loaded with the divisor and
  // the bit ends on the cycle it reads zero (divisor 0 gives one clock per bit).
  assign w_bit_done = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - ONE_D;
  assign w_bit_inc  = r_bit_idx + 3'd1;

  // txd is registered, so each branch computes the level for the state being
  // entered; this puts the start bit on the line two cycles after the push.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_div_lat_next = r_div_lat;
    w_byte_next    = r_byte;
    w_bit_idx_next = r_bit_idx;
    w_txd_next     = r_txd;
    w_fifo_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd_next = 1'b1;
        if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_byte_next    = w_fifo_dout;
          // The divisor is captured here so later writes only affect the next frame.
          w_div_lat_next = r_div;
          w_cnt_next     = r_div;
          w_txd_next     = 1'b0;
          w_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = 3'd0;
          w_cnt_next     = r_div_lat;
          w_txd_next     = r_byte[0];
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_cnt_next = r_div_lat;
          if (r_bit_idx == 3'd7) begin
`ifdef MINI16_UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
            w_txd_next   = ^r_byte;
`else
            w_state_next = ST_STOP;
            w_txd_next   = 1'b1;
`endif
          end else begin
            w_bit_idx_next = w_bit_inc;
            w_txd_next     = r_byte[w_bit_inc];
          end
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
`ifdef MINI16_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_next = ST_STOP;
          w_cnt_next   = r_div_lat;
          w_txd_next   = 1'b1;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_done) begin
          w_state_next = ST_IDLE;
          w_txd_next   = 1'b1;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div_lat <= DEFAULT_DIV;
      r_byte    <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_div_lat <= w_div_lat_next;
      r_byte    <= w_byte_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_addr == DEPTH_A'(REG_DATA)) begin
      w_rdata[STAT_FULL]  = w_fifo_full;
      w_rdata[STAT_EMPTY] = w_fifo_empty;
      w_rdata[STAT_BUSY]  = (r_state != ST_IDLE);
      w_rdata[STAT_OVF]   = r_ovf;
    end else if (r_addr == DEPTH_A'(REG_DIV)) begin
      w_rdata = r_div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= DEFAULT_DIV;
      r_ovf  <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_div_we) r_div <= w_data;
      // A dropped push wins over a simultaneous clear so no overflow goes unseen.
      if (w_ovf_set)     r_ovf <= 1'b1;
      else if (w_clr_we) r_ovf <= 1'b0;
      r_data <= w_rdata;
    end
  end

  assign txd = r_txd;

endmodule

// File: tb/tb_mini16_uart_tx.sv
// tb_mini16_uart_tx -- scoreboard bench for mini16_uart_tx.
// Stimulus pushes expected frames / read values into queues; a frame monitor
// and a read monitor pop and compare as the DUT presents them.
// Honours MINI16_UART_TX_PARITY_EN for frame length and the parity test.
module tb_mini16_uart_tx;

  localparam int WD = 16;
  localparam int DA = 2;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DA-1:0] w_addr;
  logic [WD-1:0] w_data;
  logic          we;
  logic [DA-1:0] r_addr;
  logic [WD-1:0] r_data;
  logic          txd;

  always #5 clk = ~clk;

  mini16_uart_tx #(
    .WIDTH_D     (WD),
    .DEPTH_A     (DA),
    .FIFO_DEPTH  (FD),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .w_addr (w_addr),
    .w_data (w_data),
    .we     (we),
    .r_addr (r_addr),
    .r_data (r_data),
    .txd    (txd)
  );

  typedef struct {
    logic [7:0] data;
    int         cpb;
    int         exp_start;
    bit         chk_gap;
  } frame_t;

  typedef struct {
    logic [WD-1:0] val;
    string         name;
  } rd_t;

  frame_t sb_q[$];
  rd_t    rd_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rd_issue = 1'b0;
  bit rd_pend  = 1'b0;
  bit in_frame = 1'b0;
  bit abort_ok = 1'b0;
  int last_end = -100;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pend <= rd_issue;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- read monitor ----------------
  rd_t rd_cur;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_queue: read returned 0x%0h with nothing expected", r_data);
      end else begin
        rd_cur = rd_q.pop_front();
        checks++;
        if (r_data !== rd_cur.val) begin
          errors++;
          $display("FAIL %s: r_data=0x%04h expected 0x%04h", rd_cur.name, r_data, rd_cur.val);
        end else begin
          $display("read %s = 0x%04h", rd_cur.name, r_data);
        end
      end
    end
  end

  // ---------------- frame monitor ----------------
  frame_t     mon_f;
  logic [10:0] mon_bits;
  int         mon_nb;
  int         mon_bad;
  bit         mon_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd !== 1'b0) continue;
      in_frame = 1'b1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: txd low at cycle %0d, expected idle high", cyc);
        for (int k = 0; k < 20000 && txd !== 1'b1; k++) @(negedge clk);
        in_frame = 1'b0;
        continue;
      end
      mon_f = sb_q.pop_front();
      if (mon_f.exp_start >= 0) begin
        checks++;
        if (cyc != mon_f.exp_start) begin
          errors++;
          $display("FAIL start_latency: start at cycle %0d expected %0d", cyc, mon_f.exp_start);
        end
      end
      if (mon_f.chk_gap) begin
        checks++;
        if (cyc - last_end != 2) begin
          errors++;
          $display("FAIL idle_gap: %0d idle cycles expected 1", cyc - last_end - 1);
        end
      end
`ifdef MINI16_UART_TX_PARITY_EN
      mon_nb = 11;
`else
      mon_nb = 10;
`endif
      mon_bits = '1;
      mon_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) mon_bits[i+1] = mon_f.data[i];
`ifdef MINI16_UART_TX_PARITY_EN
      mon_bits[9] = ^mon_f.data;
`endif
      mon_bad   = 0;
      mon_abort = 1'b0;
      for (int i = 0; i < mon_nb * mon_f.cpb; i++) begin
        if (i > 0) @(negedge clk);
        if (reset === 1'b1) begin
          mon_abort = 1'b1;
          break;
        end
        if (txd !== mon_bits[i / mon_f.cpb]) mon_bad++;
      end
      checks++;
      if (mon_abort) begin
        if (!abort_ok) begin
          errors++;
          $display("FAIL frame_abort: frame 0x%02h cut by reset, abort_ok=%0d expected 1", mon_f.data, abort_ok);
        end else begin
          $display("frame 0x%02h aborted by reset", mon_f.data);
        end
      end else begin
        if (mon_bad != 0) begin
          errors++;
          $display("FAIL frame: data 0x%02h cpb %0d had %0d wrong txd cycles, expected 0", mon_f.data, mon_f.cpb, mon_bad);
        end else begin
          $display("frame 0x%02h cpb %0d received", mon_f.data, mon_f.cpb);
        end
        last_end = cyc;
      end
      in_frame = 1'b0;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic mmio_write(input int addr, input logic [WD-1:0] data);
    w_addr = DA'(addr);
    w_data = data;
    we     = 1'b1;
    @(negedge clk);
    we     = 1'b0;
  endtask

  task automatic mmio_read(input int addr, input logic [WD-1:0] exp, input string name);
    rd_t r;
    r.val  = exp;
    r.name = name;
    rd_q.push_back(r);
    r_addr   = DA'(addr);
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int cpb, input bit chk_start,
                           input bit chk_gap, input bit expect_tx);
    frame_t f;
    f.data      = d;
    f.cpb       = cpb;
    f.exp_start = chk_start ? cyc + 2 : -1;
    f.chk_gap   = chk_gap;
    if (expect_tx) sb_q.push_back(f);
    mmio_write(0, {8'h00, d});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    for (k = 0; k < budget && (sb_q.size() != 0 || in_frame); k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || in_frame) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames pending after %0d cycles, expected 0", name, sb_q.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    w_addr = '0;
    w_data = '0;
    r_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_rdata", {16'd0, r_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset state through the register map
    mmio_read(0, 16'h0002, "reset_status");
    mmio_read(1, 16'd867, "reset_div");
    mmio_read(2, 16'h0000, "addr2_zero");
    mmio_write(3, 16'hFFFF);
    mmio_read(3, 16'h0000, "addr3_zero");
    repeat (4) @(negedge clk);

    // Divisor 3, single 0x55 frame with start latency check
    mmio_write(1, 16'd3);
    mmio_read(1, 16'd3, "div_3");
    send_byte(8'h55, 4, 1'b1, 1'b0, 1'b1);
    wait_drain(200, "div3_frame");

    // Divisor 0, back-to-back frames with a single idle cycle between
    mmio_write(1, 16'd0);
    send_byte(8'h80, 1, 1'b1, 1'b0, 1'b1);
    send_byte(8'h01, 1, 1'b0, 1'b1, 1'b1);
    wait_drain(100, "div0_b2b");
    mmio_read(0, 16'h0002, "status_after_b2b");

    // Divisor change mid-frame only affects the next frame
    mmio_write(1, 16'd3);
    send_byte(8'h3C, 4, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    mmio_write(1, 16'd7);
    mmio_read(1, 16'd7, "div_7");
    send_byte(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    wait_drain(400, "div_change");

    // Overflow: 1 in flight + 4 queued, sixth write dropped
    mmio_write(1, 16'd3);
    send_byte(8'hA1, 4, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    send_byte(8'hB2, 4, 1'b0, 1'b0, 1'b1);
    send_byte(8'hC3, 4, 1'b0, 1'b0, 1'b1);
    send_byte(8'hD4, 4, 1'b0, 1'b0, 1'b1);
    send_byte(8'hE5, 4, 1'b0, 1'b0, 1'b1);
    send_byte(8'hF6, 4, 1'b0, 1'b0, 1'b0);
    mmio_read(0, 16'h000D, "status_overflow");
    mmio_write(2, 16'h0000);
    mmio_read(0, 16'h0005, "status_ovf_cleared");
    wait_drain(2000, "overflow");
    mmio_read(0, 16'h0002, "status_after_overflow");

`ifdef MINI16_UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones -> 1, 0x03 has two -> 0
    mmio_write(1, 16'd1);
    send_byte(8'h07, 2, 1'b1, 1'b0, 1'b1);
    wait_drain(200, "parity_07");
    send_byte(8'h03, 2, 1'b1, 1'b0, 1'b1);
    wait_drain(200, "parity_03");
`endif

    // Reset mid-frame: line goes high at once, queued bytes discarded
    mmio_write(1, 16'd3);
    send_byte(8'h0F, 4, 1'b1, 1'b0, 1'b1);
    send_byte(8'h33, 4, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 4, 1'b0, 1'b0, 1'b0);
    repeat (22) @(negedge clk);
    check("txd_before_reset", {31'd0, txd}, 32'd0);
    abort_ok = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("txd_async_reset", {31'd0, txd}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    abort_ok = 1'b0;
    mmio_read(0, 16'h0002, "status_after_reset");
    mmio_read(1, 16'd867, "div_after_reset");
    repeat (100) @(negedge clk);
    check("pending_frames", sb_q.size(), 32'd0);
    check("pending_reads", rd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
